// File: rtl/uart_tx_fifo_if.sv
// Bus between the register side / transmitter and the UART transmit FIFO.
// The master side drives pushes and control and supplies tx_busy.
// The slave side is the FIFO, which returns the launch and status signals.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flush;
  logic                  tx_en;
  logic                  ovf_clr;
  logic                  tx_busy;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  tx_active;

  modport master (
    output wr_en, wr_data, flush, tx_en, ovf_clr, tx_busy,
    input  tx_start, tx_data, full, empty, count, overflow, tx_active
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_en, ovf_clr, tx_busy,
    output tx_start, tx_data, full, empty, count, overflow, tx_active
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and launch controller in front of the UART transmitter.
// Bytes are queued in a circular buffer and launched one at a time. Each
// launch is a 1-cycle tx_start pulse. A new launch waits until the
// transmitter has raised and then dropped tx_busy for the previous frame.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_INC = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push;
  logic                  drop;
  logic                  launch;

  // Decode this cycle's push, dropped push and launch. full is the registered
  // flag, so a push into a full FIFO is dropped even if a pop happens now.
  always_comb begin
    push   = bus.wr_en & ~full_q & ~bus.flush;
    drop   = bus.wr_en &  full_q & ~bus.flush;
    launch = (state_q == IDLE) & bus.tx_en & ~empty_q & ~bus.tx_busy & ~bus.flush;
  end

  // Next pointers, occupancy, registered flags and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_INC;
      if (launch) rd_ptr_d = rd_ptr_q + PTR_INC;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
              (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
    else                  overflow_d = overflow_q;
  end

  // Storage array: written on accepted pushes only, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
  end

  // Pointer, flag and FSM state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Launch FSM next state. WAIT_BUSY absorbs the transmitter's registered busy rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (launch) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Launch outputs: a 1-cycle start pulse and the popped byte, held until the next launch
  always_comb begin
    tx_start_d = launch;
    tx_data_d  = launch ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : tx_data_q;
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.tx_active = (state_q != IDLE);
endmodule
